// File: rtl/rgb_pkg.sv
// Shared types and constants for the card-triggered LED pattern fader.
package rgb_pkg;

   typedef logic [23:0] rgb_t;

   localparam int BASE_LEDS = 6;
   localparam int ID_W      = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } fade_state_t;

   function automatic rgb_t mk_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/rgb_pattern_rom.sv
// Card id to LED string lookup; the 6-entry base pattern repeats along the string.
module rgb_pattern_rom
   import rgb_pkg::*;
#(
   parameter int NUM_LEDS = 6
) (
   input  logic [ID_W-1:0]       id,
   output logic [NUM_LEDS*24-1:0] pattern,
   output logic                  hit
);

   function automatic rgb_t base_colour(input logic [ID_W-1:0] sel, input int idx);
      rgb_t c;
      c = '0;
      if (sel == ID_W'(1)) begin
         case (idx)
            0:       c = mk_rgb(8'd28,  8'd252, 8'd3);
            1:       c = mk_rgb(8'd159, 8'd245, 8'd47);
            2:       c = mk_rgb(8'd245, 8'd252, 8'd23);
            3:       c = mk_rgb(8'd252, 8'd92,  8'd23);
            4:       c = mk_rgb(8'd141, 8'd23,  8'd252);
            default: c = mk_rgb(8'd23,  8'd157, 8'd252);
         endcase
      end else if (sel == ID_W'(2)) begin
         if (idx < 3) c = mk_rgb(8'd127, 8'd50,  8'd168);
         else         c = mk_rgb(8'd159, 8'd245, 8'd47);
      end
      return c;
   endfunction

   always_comb begin
      hit     = (id == ID_W'(1)) || (id == ID_W'(2));
      pattern = '0;
      // LED0 occupies the most significant word
      for (int i = 0; i < NUM_LEDS; i++) begin
         pattern[(NUM_LEDS-i)*24-1 -: 24] = base_colour(id, i % BASE_LEDS);
      end
   end

endmodule

// File: rtl/rgb_pattern_fader.sv
// Crossfades the LED string from the displayed colours to a card's pattern and
// hands each intermediate frame to the LED driver over valid/ready.
module rgb_pattern_fader
   import rgb_pkg::*;
#(
   parameter int NUM_LEDS    = 6,
   parameter int FADE_LOG2   = 3,
   parameter int STEP_CYCLES = 250000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ID_W-1:0]        id,
   input  logic                   song_start,
   input  logic                   frame_ready,
   output logic [NUM_LEDS*24-1:0] rgb,
   output logic                   frame_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   id_miss
);

   localparam int RGB_W = NUM_LEDS * 24;
   localparam int CH    = NUM_LEDS * 3;
   localparam int SW    = FADE_LOG2 + 1;
   localparam int AW    = 8 + FADE_LOG2 + 1;
   localparam int PW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [SW-1:0] FULL_STEP = SW'(1) << FADE_LOG2;
   localparam logic [PW-1:0] LAST_TICK = PW'(STEP_CYCLES - 1);

   fade_state_t      state;
   logic [SW-1:0]    step;
   logic [PW-1:0]    presc;
   logic [RGB_W-1:0] old_rgb;
   logic [RGB_W-1:0] target_rgb;
   logic [RGB_W-1:0] blended;
   logic [RGB_W-1:0] rom_pattern;
   logic             rom_hit;

   rgb_pattern_rom #(
      .NUM_LEDS (NUM_LEDS)
   ) u_rom (
      .id      (id),
      .pattern (rom_pattern),
      .hit     (rom_hit)
   );

   // Weighted mix of one 8-bit channel; the final step weights target fully.
   function automatic logic [7:0] blend_channel(input logic [7:0] a, input logic [7:0] b,
                                                input logic [SW-1:0] s);
      logic [AW-1:0] acc;
      acc = AW'(a) * AW'(FULL_STEP - s) + AW'(b) * AW'(s);
      return acc[FADE_LOG2 +: 8];
   endfunction

   for (genvar c = 0; c < CH; c++) begin : g_blend
      assign blended[c*8 +: 8] = blend_channel(old_rgb[c*8 +: 8], target_rgb[c*8 +: 8], step);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         step        <= '0;
         presc       <= '0;
         old_rgb     <= '0;
         target_rgb  <= '0;
         rgb         <= '0;
         frame_valid <= 1'b0;
         done        <= 1'b0;
         id_miss     <= 1'b0;
      end else begin
         done    <= 1'b0;
         id_miss <= song_start && !rom_hit;
         // A hit restarts from whatever is on screen, withdrawing any pending frame
         if (song_start && rom_hit) begin
            old_rgb     <= rgb;
            target_rgb  <= rom_pattern;
            step        <= SW'(1);
            presc       <= '0;
            frame_valid <= 1'b0;
            state       <= WAIT;
         end else begin
            case (state)
               IDLE: begin
                  frame_valid <= 1'b0;
               end
               WAIT: begin
                  if (presc == LAST_TICK) begin
                     rgb         <= blended;
                     frame_valid <= 1'b1;
                     state       <= SEND;
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               SEND: begin
                  if (frame_ready) begin
                     frame_valid <= 1'b0;
                     if (step == FULL_STEP) begin
                        done  <= 1'b1;
                        state <= IDLE;
                     end else begin
                        step  <= step + SW'(1);
                        presc <= '0;
                        state <= WAIT;
                     end
                  end
               end
               default: begin
                  frame_valid <= 1'b0;
                  state       <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
